// File: rtl/uart_tx_pkg.sv
// Shared FSM encoding and framing constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int MAX_DATA_W = 9;
  localparam int CNT_W      = 4;  // wide enough to count MAX_DATA_W bit times
  localparam int STOP_ONE   = 1;
  localparam int STOP_TWO   = 2;
  localparam logic PARITY_ODD = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } tx_state_e;

  function automatic logic parity_of(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ (odd == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO feeding the UART shifter; wrap-around pointers carry one
// extra bit so that occupancy is simply their difference.
module uart_tx_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     baud_clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge baud_clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone define
  // which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge baud_clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO plus start/data/parity/stop serialiser, one bit
// per baud_clk cycle. Define UART_TX_PARITY_EN to build in parity generation.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   baud_clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ack,
  input  logic                   tx_en,
  input  logic                   rx_ready,
  input  logic                   flush,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   two_stop,
  output logic                   txd,
  output logic                   tx_busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] fifo_head;
  logic              two_stop_q;
  logic              wr_accept;
  logic              load_ok;
  logic              pop;
  logic              data_last;
  logic              stop_last;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  assign wr_accept = wr_en && !full && !flush;
  assign load_ok   = !empty && tx_en && rx_ready;
  assign data_last = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign stop_last = (bit_cnt_q == (two_stop_q ? CNT_W'(STOP_TWO - 1) : CNT_W'(STOP_ONE - 1)));
  // START is only ever entered by taking a byte from the FIFO.
  assign pop       = (state_d == START);

  uart_tx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .baud_clk  (baud_clk),
    .rst       (rst),
    .flush     (flush),
    .push      (wr_accept),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (load_ok) state_d = START;
      START: state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (data_last) state_d = par_en_q ? PARITY : STOP;
      PARITY: state_d = STOP;
`else
      DATA:  if (data_last) state_d = STOP;
`endif
      STOP:  if (stop_last) state_d = load_ok ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd     = 1'b1;
    tx_busy = 1'b1;
    case (state_q)
      IDLE:   tx_busy = 1'b0;
      START:  txd = 1'b0;
      DATA:   txd = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd = par_bit_q;
`endif
      STOP:   txd = 1'b1;
      default: begin
        txd     = 1'b1;
        tx_busy = 1'b0;
      end
    endcase
  end

  // Frame options are captured with the byte so mid-frame changes cannot
  // corrupt a frame already on the line.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      shreg_q    <= '0;
      two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else if (pop) begin
      shreg_q    <= fifo_head;
      two_stop_q <= two_stop;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= parity_en;
      par_bit_q  <= parity_of(MAX_DATA_W'(fifo_head), parity_odd);
`endif
    end else if (state_q == DATA) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (rst) wr_ack <= 1'b0;
    else     wr_ack <= wr_accept;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected line frames,
// a negedge monitor reassembles txd frames and compares them.
module tb_uart_tx_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              baud_clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              tx_en;
  logic              rx_ready;
  logic              flush;
  logic              parity_en;
  logic              parity_odd;
  logic              two_stop;
  logic              txd;
  logic              tx_busy;
  logic              full;
  logic              empty;
  logic [$clog2(DEPTH):0] level;

  uart_tx_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .tx_en      (tx_en),
    .rx_ready   (rx_ready),
    .flush      (flush),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .full       (full),
    .empty      (empty),
    .level      (level)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  typedef struct {
    logic [11:0] bits;  // bit i is the i-th bit on the line, start bit first
    int          len;
  } frame_t;

  frame_t sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     mon_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic expect_frame(input logic [11:0] bits, input int len);
    sb_q.push_back('{bits: bits, len: len});
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int c = 0;
    while ((tx_busy || !empty) && c < max_cycles) begin
      tick();
      c++;
    end
    check("idle_timeout", 32'(tx_busy || !empty), 0);
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] bits, input int len);
    expect_frame(bits, len);
    write_byte(d);
    wait_idle(40);
  endtask

  // Monitor: collects one frame per scoreboard entry while the line is busy.
  int          bit_idx = 0;
  int          cur_len = 10;
  logic [11:0] got     = '0;
  logic [11:0] cur_exp = '0;
  bit          stray   = 1'b0;

  always @(negedge baud_clk) begin
    if (rst || !mon_en) begin
      bit_idx = 0;
      got     = '0;
    end else if (tx_busy || bit_idx != 0) begin
      if (bit_idx == 0) begin
        stray   = (sb_q.size() == 0);
        cur_len = stray ? 10 : sb_q[0].len;
        cur_exp = stray ? '0 : sb_q[0].bits;
      end
      got[bit_idx] = txd;
      bit_idx++;
      if (bit_idx == cur_len) begin
        if (stray) begin
          check("unexpected_frame", 1, 0);
        end else begin
          check("frame", 32'(got), 32'(cur_exp));
          void'(sb_q.pop_front());
        end
        bit_idx = 0;
        got     = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acks;
    int busy_cnt;
    bit seen;

    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h5A; tx_en = 1'b1; rx_ready = 1'b1;
    flush = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) tick();
    check("rst_txd", 32'(txd), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_level", 32'(level), 0);
    check("rst_wr_ack", 32'(wr_ack), 0);
    rst = 1'b0; wr_en = 1'b0;
    tick();

    // 0xA5, 8N1: write at edge N, ack after N, START after N+1.
    expect_frame(12'({1'b1, 8'hA5, 1'b0}), 10);
    write_byte(8'hA5);
    check("a5_ack", 32'(wr_ack), 1);
    check("a5_idle_txd", 32'(txd), 1);
    check("a5_idle_busy", 32'(tx_busy), 0);
    check("a5_level", 32'(level), 1);
    tick();
    check("a5_ack_pulse", 32'(wr_ack), 0);
    check("a5_start_txd", 32'(txd), 0);
    check("a5_start_busy", 32'(tx_busy), 1);
    check("a5_popped_empty", 32'(empty), 1);
    wait_idle(40);

    // Parity on 0x07 (three ones): even -> 1, odd -> 0.
    parity_en = 1'b1;
    parity_odd = 1'b0;
`ifdef UART_TX_PARITY_EN
    send(8'h07, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
    parity_odd = 1'b1;
    send(8'h07, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
`else
    send(8'h07, 12'({1'b1, 8'h07, 1'b0}), 10);
    parity_odd = 1'b1;
    send(8'h07, 12'({1'b1, 8'h07, 1'b0}), 10);
`endif

    // Two stop bits on 0x3C; options change mid-frame and must be ignored.
    parity_odd = 1'b0;
    two_stop   = 1'b1;
`ifdef UART_TX_PARITY_EN
    expect_frame(12'({2'b11, 1'b0, 8'h3C, 1'b0}), 12);
`else
    expect_frame(12'({2'b11, 8'h3C, 1'b0}), 11);
`endif
    write_byte(8'h3C);
    tick();
    check("twostop_start", 32'(txd), 0);
    two_stop = 1'b0; parity_en = 1'b0; parity_odd = 1'b1;
    wait_idle(40);
    parity_odd = 1'b0;

    // Fill with the engine disabled: 17 writes, the last one dropped.
    tx_en = 1'b0;
    acks  = 0;
    wr_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wr_data = 8'(8'h10 + k);
      tick();
      check("fill_ack", 32'(wr_ack), (k < 16) ? 1 : 0);
      if (wr_ack) acks++;
    end
    wr_en = 1'b0;
    check("fill_ack_count", acks, 16);
    check("fill_full", 32'(full), 1);
    check("fill_level", 32'(level), 16);
    check("fill_txd_idle", 32'(txd), 1);
    for (int k = 0; k < 16; k++) expect_frame(12'({1'b1, 8'(8'h10 + k), 1'b0}), 10);
    // Write while full coinciding with a pop is still dropped.
    wr_en = 1'b1; wr_data = 8'hEE; tx_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check("full_pop_no_ack", 32'(wr_ack), 0);
    check("full_pop_level", 32'(level), 15);
    check("full_pop_busy", 32'(tx_busy), 1);
    wait_idle(200);
    check("drain_level", 32'(level), 0);

    // Three queued bytes go out back-to-back: 30 busy cycles.
    tx_en = 1'b0;
    write_byte(8'h55);
    write_byte(8'hC3);
    write_byte(8'h0F);
    expect_frame(12'({1'b1, 8'h55, 1'b0}), 10);
    expect_frame(12'({1'b1, 8'hC3, 1'b0}), 10);
    expect_frame(12'({1'b1, 8'h0F, 1'b0}), 10);
    tx_en = 1'b1;
    tick();
    check("b2b_level_after_pop", 32'(level), 2);
    busy_cnt = 0;
    while (tx_busy && busy_cnt < 50) begin
      busy_cnt++;
      tick();
    end
    check("b2b_busy_cycles", busy_cnt, 30);
    check("b2b_empty", 32'(empty), 1);

    // Flush mid-frame with five queued: current frame finishes, nothing else.
    tx_en = 1'b0;
    for (int k = 0; k < 5; k++) write_byte(8'(8'h31 + k));
    check("flush_pre_level", 32'(level), 5);
    expect_frame(12'({1'b1, 8'h31, 1'b0}), 10);
    tx_en = 1'b1;
    tick();
    check("flush_pre_busy", 32'(tx_busy), 1);
    repeat (3) tick();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    check("flush_level", 32'(level), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_write_no_ack", 32'(wr_ack), 0);
    check("flush_frame_continues", 32'(tx_busy), 1);
    wait_idle(20);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (tx_busy) seen = 1'b1;
    end
    check("flush_no_more_frames", 32'(seen), 0);

    // rx_ready low holds the line idle; its rise starts a frame next edge.
    rx_ready = 1'b0;
    expect_frame(12'({1'b1, 8'h96, 1'b0}), 10);
    write_byte(8'h96);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (tx_busy || !txd) seen = 1'b1;
    end
    check("rxready_hold", 32'(seen), 0);
    rx_ready = 1'b1;
    tick();
    check("rxready_start_busy", 32'(tx_busy), 1);
    check("rxready_start_txd", 32'(txd), 0);
    wait_idle(40);

    // Reset mid-frame aborts with the line high; writes during reset are lost.
    mon_en = 1'b0;
    write_byte(8'h00);
    repeat (3) tick();
    check("abort_in_frame", 32'(tx_busy), 1);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h42;
    tick();
    check("abort_txd", 32'(txd), 1);
    check("abort_busy", 32'(tx_busy), 0);
    check("abort_level", 32'(level), 0);
    check("abort_empty", 32'(empty), 1);
    check("abort_full", 32'(full), 0);
    check("abort_wr_ack", 32'(wr_ack), 0);
    rst = 1'b0; wr_en = 1'b0;
    mon_en = 1'b1;
    tick();
    tick();
    check("post_abort_idle", 32'(tx_busy), 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >=2).
REQ-003 SHALL have port baud_clk, input, 1, sole clock; one UART bit per cycle.
REQ-004 SHALL have port rst, input, 1. Reset is synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, write strobe.
REQ-006 SHALL have port wr_data, input, DATA_W, write data.
REQ-007 SHALL have port wr_ack, output, 1, one-cycle pulse confirming a stored write.
REQ-008 SHALL have port tx_en, input, 1, permits frame starts (active-high).
REQ-009 SHALL have port rx_ready, input, 1, far-end ready; gates frame starts only.
REQ-010 SHALL have port flush, input, 1, discards FIFO contents.
REQ-011 SHALL have port parity_en, input, 1, appends a parity bit.
REQ-012 SHALL have port parity_odd, input, 1, odd (1) or even (0) parity.
REQ-013 SHALL have port two_stop, input, 1, two stop bits (1) or one (0).
REQ-014 SHALL have port txd, output, 1, serial line; idle high.
REQ-015 SHALL have port tx_busy, output, 1, high while a frame is on the line.
REQ-016 SHALL have ports full and empty, output, 1 each, FIFO flags.
REQ-017 SHALL have port level, output, $clog2(DEPTH)+1, FIFO occupancy, shift register excluded.

Function
REQ-018 SHALL store wr_data when wr_en && !full, pulsing wr_ack on the next cycle; a write while full is dropped with no wr_ack, even if a pop occurs in the same cycle.
REQ-019 SHALL use wrap-around pointers with one extra bit; full = (level==DEPTH), empty = (level==0); a simultaneous push and pop leaves level unchanged.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL, in IDLE with !empty && tx_en && rx_ready, pop the head into the shift register, latch parity_en, parity_odd and two_stop, and enter START.
REQ-022 SHALL drive txd=0 for one cycle in START, then drive DATA_W bits LSB first, one per cycle, in DATA.
REQ-023 SHALL drive PARITY for one cycle only when the latched parity_en is set; the bit is the XOR of the data bits, inverted when the latched parity_odd is set.
REQ-024 SHALL drive txd=1 in STOP for 1 or 2 cycles, per the latched two_stop.
REQ-025 SHALL evaluate the IDLE load condition during the final stop cycle; when it holds, the next cycle is START with no idle gap (back-to-back frames).
REQ-026 SHALL complete a started frame regardless of tx_en, rx_ready or flush deasserting or asserting mid-frame.
REQ-027 SHALL, on flush, clear both pointers and level on the next edge; flush with wr_en drops the write with no wr_ack; a frame already in the shift register is unaffected.
REQ-028 SHALL keep tx_busy=1 from START through the last stop cycle.
REQ-029 SHALL have latency: write accepted at edge N into an empty FIFO with the engine idle and enabled -> START (txd=0) at N+2.

Reset
REQ-030 SHALL, on rst, set FSM=IDLE, pointers=0, level=0, empty=1, full=0, wr_ack=0, tx_busy=0 and txd=1; a frame in progress is aborted with the line left high.

Configuration
REQ-031 SHALL gate parity generation with macro UART_TX_PARITY_EN: when defined, REQ-023 applies; when undefined, the PARITY state, parity_en and parity_odd are compiled out (ports retained and ignored) and frames never carry parity.

Structure
REQ-032 SHALL place the FSM state enum and parity/stop-bit constants in package uart_tx_pkg.
REQ-033 SHALL implement storage as sub-module uart_tx_sync_fifo (push/pop, full, empty, level); uart_tx_engine holds the FSM and shifter.

Verification
REQ-034 SHALL cover: DATA_W=8, 1 stop, no parity; write 0xA5 while idle -> txd 0,1,0,1,0,0,1,0,1,1 starting at N+2; wr_ack at N+1.
REQ-035 SHALL cover: parity_en=1, parity_odd=0; write 0x07 -> parity bit 1; with parity_odd=1 -> 0.
REQ-036 SHALL cover: DEPTH=16, tx_en=0; 17 writes -> 16 wr_acks, full=1, level=16; the 17th write is dropped.
REQ-037 SHALL cover: 3 queued bytes, two_stop=0 -> frames back-to-back, 30 consecutive busy cycles, empty=1 after the third pop.
REQ-038 SHALL cover: flush mid-frame with 5 queued bytes -> level=0 next cycle; current frame completes intact; no further frames.
REQ-039 SHALL cover: rx_ready=0 with data queued -> txd stays 1; rx_ready rises -> START on the following cycle.
